// File: rtl/load_align_pkg.sv
// load_align_pkg: load type encoding and byte-lane helper shared by the
// load alignment unit and its combinational datapath.
`timescale 1ns/1ps
package load_align_pkg;

  typedef enum logic [3:0] {
    LB  = 4'd0,
    LBU = 4'd1,
    LH  = 4'd2,
    LHU = 4'd3,
    LW  = 4'd4,
    LWU = 4'd5,
    LD  = 4'd6,
    LWL = 4'd7,
    LWR = 4'd8
  } load_type_t;

  localparam logic [7:0] FAULT_CNT_MAX = 8'hFF;

  // Byte k of a big-endian word that occupies the low nbytes*8 bits of data.
  // Byte 0 is the most significant lane.
  function automatic logic [7:0] lane_byte(input logic [63:0] data,
                                           input int          nbytes,
                                           input logic [2:0]  k);
    logic [5:0] idx;
    idx = 6'((nbytes - 1 - int'(k)) * 8);
    return data[idx +: 8];
  endfunction

endpackage

// File: rtl/load_align_unit_comb.sv
// load_align_comb: purely combinational extraction, sign/zero extension and
// LWL/LWR merge of a big-endian memory word.
`timescale 1ns/1ps
module load_align_comb
  import load_align_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [3:0]        i_type,
  input  logic [OFF_W-1:0]  i_offset,
  input  logic [DATA_W-1:0] i_data,
  input  logic [31:0]       i_base,
  output logic [DATA_W-1:0] o_data
);

  localparam int NB = DATA_W / 8;

  logic [63:0] w_data64;
  logic [2:0]  w_off;
  logic [2:0]  w_hoff;
  logic [2:0]  w_woff;
  logic [1:0]  w_k;
  logic [4:0]  w_shl;
  logic [4:0]  w_shr;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_word;
  logic [31:0] w_lwl;
  logic [31:0] w_lwr;
  logic [63:0] w_res;
  logic        w_unused_res;

  assign w_data64 = 64'(i_data);
  assign w_off    = 3'(i_offset);
  // Halfword and word selections round the offset down to their natural size.
  assign w_hoff   = {w_off[2:1], 1'b0};
  assign w_woff   = {w_off[2], 2'b00};
  assign w_k      = w_off[1:0];

  assign w_byte = lane_byte(w_data64, NB, w_off);
  assign w_half = {lane_byte(w_data64, NB, w_hoff),
                   lane_byte(w_data64, NB, w_hoff | 3'd1)};
  assign w_word = {lane_byte(w_data64, NB, w_woff),
                   lane_byte(w_data64, NB, w_woff | 3'd1),
                   lane_byte(w_data64, NB, w_woff | 3'd2),
                   lane_byte(w_data64, NB, w_woff | 3'd3)};

  // LWL keeps the low 8k bits of the base; LWR keeps the high 8(3-k) bits.
  // 3-k on a 2-bit value is its bitwise inverse.
  assign w_shl = {w_k, 3'b000};
  assign w_shr = {~w_k, 3'b000};
  assign w_lwl = (w_word << w_shl) | (i_base & ((32'd1 << w_shl) - 32'd1));
  assign w_lwr = (w_word >> w_shr) | (i_base & ~(32'hFFFF_FFFF >> w_shr));

  // Select and extend the result for the requested load type.
  always_comb begin
    w_res = w_data64;
    case (i_type)
      LB:  w_res = {{56{w_byte[7]}}, w_byte};
      LBU: w_res = {56'h0, w_byte};
      LH:  w_res = {{48{w_half[15]}}, w_half};
      LHU: w_res = {48'h0, w_half};
      LW:  w_res = {{32{w_word[31]}}, w_word};
      LWU: w_res = (NB == 8) ? {32'h0, w_word} : {{32{w_word[31]}}, w_word};
      LD:  w_res = (NB == 8) ? w_data64 : {{32{w_word[31]}}, w_word};
      LWL: w_res = {{32{w_lwl[31]}}, w_lwl};
      LWR: w_res = {{32{w_lwr[31]}}, w_lwr};
      default: w_res = w_data64;
    endcase
  end

  assign o_data = w_res[DATA_W-1:0];

  // Upper half of the 64-bit working value is dropped in 32-bit builds.
  assign w_unused_res = ^w_res;

endmodule

// File: rtl/load_align_unit.sv
// load_align_unit: single-register-stage load alignment with LWL/LWR merge
// forwarding. Optional misaligned-access fault detection and a saturating
// fault counter are enabled by defining LOAD_ALIGN_FAULT_EN.
//
// Handshake: a request transfers when in_valid && in_ready, with
// in_ready = !out_valid || out_ready. The result appears one cycle later and
// is held stable until out_valid && out_ready.
`timescale 1ns/1ps
module load_align_unit
  import load_align_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_type,
  input  logic [OFF_W-1:0]  in_offset,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_rt_old,
  input  logic [4:0]        in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_rd
`ifdef LOAD_ALIGN_FAULT_EN
  ,
  output logic              out_fault,
  output logic [7:0]        fault_cnt
`endif
);

  logic              w_in_ready;
  logic              w_accept;
  logic              w_fwd;
  logic [31:0]       w_base;
  logic [DATA_W-1:0] w_result;
  logic [DATA_W-1:0] w_next_data;
  logic              w_unused_rt;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [4:0]        r_out_rd;

  assign w_in_ready = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;

  // A result still sitting in the output register has not reached the
  // register file yet, so a merge to the same destination must build on it.
  assign w_fwd  = r_out_valid && (r_out_rd == in_rd);
  assign w_base = w_fwd ? r_out_data[31:0] : in_rt_old[31:0];

  // Only the low word of in_rt_old takes part in a merge.
  assign w_unused_rt = ^in_rt_old;

  load_align_comb #(
    .DATA_W (DATA_W)
  ) u_comb (
    .i_type   (in_type),
    .i_offset (in_offset),
    .i_data   (in_data),
    .i_base   (w_base),
    .o_data   (w_result)
  );

`ifdef LOAD_ALIGN_FAULT_EN
  logic [2:0] w_off3;
  logic       w_misaligned;
  logic       r_out_fault;
  logic [7:0] r_fault_cnt;

  assign w_off3 = 3'(in_offset);

  // Flag accesses whose offset is not a multiple of the access size.
  always_comb begin
    w_misaligned = 1'b0;
    case (in_type)
      LH, LHU: w_misaligned = w_off3[0];
      LW, LWU: w_misaligned = |w_off3[1:0];
      LD:      w_misaligned = (DATA_W == 64) && (|w_off3);
      default: w_misaligned = 1'b0;
    endcase
  end

  assign w_next_data = w_misaligned ? '0 : w_result;

  // Fault flag travels with the result it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_fault <= 1'b0;
    end else if (w_accept) begin
      r_out_fault <= w_misaligned;
    end
  end

  // Count accepted misaligned loads, holding at the maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault_cnt <= 8'h00;
    end else if (w_accept && w_misaligned && (r_fault_cnt != FAULT_CNT_MAX)) begin
      r_fault_cnt <= r_fault_cnt + 8'd1;
    end
  end

  assign out_fault = r_out_fault;
  assign fault_cnt = r_fault_cnt;
`else
  assign w_next_data = w_result;
`endif

  // Output register: load on transfer, drop valid once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_rd    <= 5'd0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_next_data;
      r_out_rd    <= in_rd;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_rd    = r_out_rd;

endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit: drives a 32-bit and a 64-bit instance of
// load_align_unit with directed and random loads. Expected results come from
// a byte-level reference model and are queued at acceptance; a monitor on the
// falling edge compares every presented result against the queue head.
`timescale 1ns/1ps
module tb_load_align_unit;
  import load_align_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- stimulus signals (index 0: 32-bit, 1: 64-bit) ----------------
  logic        vld  [2];
  logic        ordy [2];
  logic [3:0]  typ  [2];
  logic [2:0]  off  [2];
  logic [63:0] dat  [2];
  logic [63:0] rto  [2];
  logic [4:0]  rdi  [2];

  logic        irdy_a, ovld_a, irdy_b, ovld_b;
  logic [31:0] odat_a;
  logic [63:0] odat_b;
  logic [4:0]  ord_a, ord_b;
`ifdef LOAD_ALIGN_FAULT_EN
  logic        flt_a, flt_b;
  logic [7:0]  fcnt_a, fcnt_b;
`endif

  load_align_unit #(.DATA_W(32)) u_dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (vld[0]),
    .in_ready  (irdy_a),
    .in_type   (typ[0]),
    .in_offset (off[0][1:0]),
    .in_data   (dat[0][31:0]),
    .in_rt_old (rto[0][31:0]),
    .in_rd     (rdi[0]),
    .out_valid (ovld_a),
    .out_ready (ordy[0]),
    .out_data  (odat_a),
    .out_rd    (ord_a)
`ifdef LOAD_ALIGN_FAULT_EN
    ,
    .out_fault (flt_a),
    .fault_cnt (fcnt_a)
`endif
  );

  load_align_unit #(.DATA_W(64)) u_dut64 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (vld[1]),
    .in_ready  (irdy_b),
    .in_type   (typ[1]),
    .in_offset (off[1]),
    .in_data   (dat[1]),
    .in_rt_old (rto[1]),
    .in_rd     (rdi[1]),
    .out_valid (ovld_b),
    .out_ready (ordy[1]),
    .out_data  (odat_b),
    .out_rd    (ord_b)
`ifdef LOAD_ALIGN_FAULT_EN
    ,
    .out_fault (flt_b),
    .fault_cnt (fcnt_b)
`endif
  );

  // ---------------- scoreboard state ----------------
  // Queue entries are {fault, rd[4:0], data[63:0]}.
  logic [69:0] exp_q0[$];
  logic [69:0] exp_q1[$];
  int          total = 0;
  int          bad   = 0;

  // Reference view of the output register and fault counter.
  bit          m_hv [2];
  logic [63:0] m_hd [2];
  logic [4:0]  m_hr [2];
  int          m_fc [2];

  function automatic logic get_irdy(input int s);
    return (s == 0) ? irdy_a : irdy_b;
  endfunction

  function automatic logic get_ovld(input int s);
    return (s == 0) ? ovld_a : ovld_b;
  endfunction

  function automatic logic [69:0] get_out(input int s);
    logic f;
    f = 1'b0;
`ifdef LOAD_ALIGN_FAULT_EN
    f = (s == 0) ? flt_a : flt_b;
`endif
    if (s == 0) return {f, ord_a, 32'h0, odat_a};
    return {f, ord_b, odat_b};
  endfunction

`ifdef LOAD_ALIGN_FAULT_EN
  function automatic logic [7:0] get_fcnt(input int s);
    return (s == 0) ? fcnt_a : fcnt_b;
  endfunction
`endif

  function automatic int qsize(input int s);
    return (s == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [69:0] qfront(input int s);
    if (s == 0) return exp_q0[0];
    return exp_q1[0];
  endfunction

  task automatic qpush(input int s, input logic [69:0] v);
    if (s == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endtask

  task automatic qpop(input int s);
    if (s == 0) void'(exp_q0.pop_front());
    else        void'(exp_q1.pop_front());
  endtask

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Works on byte lists: byte 0 is the most significant lane of the word.
  function automatic logic [63:0] ref_load(input int nb, input logic [3:0] t, input int o,
                                           input logic [63:0] d, input logic [31:0] r);
    logic [7:0]  b  [8];
    logic [7:0]  wb [4];
    logic [7:0]  rb [4];
    logic [7:0]  mb [4];
    logic [31:0] w, m;
    logic [15:0] h;
    logic [63:0] res;
    int          wo, ho, k;
    for (int i = 0; i < 8; i++) b[i] = (i < nb) ? d[(nb-1-i)*8 +: 8] : 8'h00;
    wo = (o / 4) * 4;
    ho = (o / 2) * 2;
    k  = o % 4;
    for (int i = 0; i < 4; i++) begin
      wb[i] = b[wo+i];
      rb[i] = r[31-8*i -: 8];
    end
    w = {wb[0], wb[1], wb[2], wb[3]};
    h = {b[ho], b[ho+1]};
    case (t)
      4'd0: res = $signed(b[o]);
      4'd1: res = {56'h0, b[o]};
      4'd2: res = $signed(h);
      4'd3: res = {48'h0, h};
      4'd4: res = $signed(w);
      4'd5: res = (nb == 8) ? {32'h0, w} : 64'($signed(w));
      4'd6: res = (nb == 8) ? d : 64'($signed(w));
      4'd7: begin
        // Word bytes k..3 fill the top, base bytes fill what is left.
        for (int j = 0; j < 4; j++) begin
          if (j < 4 - k) mb[j] = wb[j+k];
          else           mb[j] = rb[j];
        end
        m = {mb[0], mb[1], mb[2], mb[3]};
        res = $signed(m);
      end
      4'd8: begin
        // Base keeps its top 3-k bytes, word bytes 0..k follow.
        for (int j = 0; j < 4; j++) begin
          if (j < 3 - k) mb[j] = rb[j];
          else           mb[j] = wb[j-(3-k)];
        end
        m = {mb[0], mb[1], mb[2], mb[3]};
        res = $signed(m);
      end
      default: res = d;
    endcase
    if (nb == 4) res[63:32] = 32'h0;
    return res;
  endfunction

  function automatic bit ref_mis(input int nb, input logic [3:0] t, input int o);
    if ((t == 4'd2 || t == 4'd3) && (o % 2 != 0)) return 1'b1;
    if ((t == 4'd4 || t == 4'd5) && (o % 4 != 0)) return 1'b1;
    if ((t == 4'd6) && (nb == 8) && (o != 0))     return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- driver ----------------
  // Called 1 ns after a rising edge; returns 1 ns after the next one.
  task automatic cycle(input int s, input bit v, input logic [3:0] t, input int o,
                       input logic [63:0] d, input logic [63:0] r, input logic [4:0] rx,
                       input bit orr, input bit use_exp, input logic [63:0] expd);
    int          nb;
    logic [63:0] base, res;
    bit          rdy, acc, mis;
    nb = (s == 0) ? 4 : 8;
    if (s == 0) begin
      d[63:32] = 32'h0;
      r[63:32] = 32'h0;
    end
    vld[s] = v; typ[s] = t; off[s] = 3'(o); dat[s] = d; rto[s] = r; rdi[s] = rx; ordy[s] = orr;
    #1;
    rdy = !m_hv[s] || orr;
    chk("in_ready", 70'(get_irdy(s)), 70'(rdy));
    acc = v && rdy;
    if (acc) begin
      base = (m_hv[s] && m_hr[s] == rx) ? m_hd[s] : r;
      res  = use_exp ? expd : ref_load(nb, t, o, d, base[31:0]);
      mis  = 1'b0;
`ifdef LOAD_ALIGN_FAULT_EN
      mis = ref_mis(nb, t, o);
      if (mis) begin
        res = 64'h0;
        if (m_fc[s] < 255) m_fc[s]++;
      end
`endif
      qpush(s, {mis, rx, res});
      m_hv[s] = 1'b1;
      m_hd[s] = res;
      m_hr[s] = rx;
    end else if (orr) begin
      m_hv[s] = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 70'(get_ovld(s)), 70'(m_hv[s]));
`ifdef LOAD_ALIGN_FAULT_EN
    chk("fault_cnt", 70'(get_fcnt(s)), 70'(m_fc[s]));
`endif
  endtask

  task automatic dir(input int s, input logic [3:0] t, input int o, input logic [63:0] d,
                     input logic [63:0] r, input logic [4:0] rx, input bit orr,
                     input logic [63:0] expd);
    cycle(s, 1'b1, t, o, d, r, rx, orr, 1'b1, expd);
  endtask

  task automatic mdl(input int s, input bit v, input logic [3:0] t, input int o,
                     input logic [63:0] d, input logic [63:0] r, input logic [4:0] rx,
                     input bit orr);
    cycle(s, v, t, o, d, r, rx, orr, 1'b0, 64'h0);
  endtask

  task automatic drain(input int s);
    repeat (3) mdl(s, 1'b0, 4'd0, 0, 64'h0, 64'h0, 5'd0, 1'b1);
  endtask

  task automatic rand_run(input int s, input int n);
    int nb;
    nb = (s == 0) ? 4 : 8;
    repeat (n) begin
      mdl(s, $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom_range(0, nb - 1),
          {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom_range(0, 3)),
          $urandom_range(0, 3) != 0);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (rst_n && get_ovld(s)) begin
        if (qsize(s) == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: dut %0d presented %h with no expectation", s, get_out(s));
        end else begin
          chk("out_result", get_out(s), qfront(s));
          if (ordy[s]) qpop(s);
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      vld[s] = 1'b0; ordy[s] = 1'b1; typ[s] = 4'd0; off[s] = 3'd0;
      dat[s] = 64'h0; rto[s] = 64'h0; rdi[s] = 5'd0;
      m_hv[s] = 1'b0; m_hd[s] = 64'h0; m_hr[s] = 5'd0; m_fc[s] = 0;
    end
    #1;
    // Reset values are visible before any clock edge.
    chk("rst_valid32", 70'(ovld_a), 70'd0);
    chk("rst_out32", get_out(0), 70'd0);
    chk("rst_valid64", 70'(ovld_b), 70'd0);
    chk("rst_out64", get_out(1), 70'd0);
`ifdef LOAD_ALIGN_FAULT_EN
    chk("rst_fcnt32", 70'(fcnt_a), 70'd0);
    chk("rst_fcnt64", 70'(fcnt_b), 70'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ---- 32-bit: extraction and extension ----
    dir(0, LB,  0, 64'h8142_C3F4, 64'h0, 5'd10, 1'b1, 64'hFFFF_FF81);
    dir(0, LBU, 3, 64'h8142_C3F4, 64'h0, 5'd11, 1'b1, 64'h0000_00F4);
    dir(0, LH,  2, 64'h8142_C3F4, 64'h0, 5'd12, 1'b1, 64'hFFFF_C3F4);
    dir(0, LWL, 1, 64'h1122_3344, 64'hAABB_CCDD, 5'd1, 1'b1, 64'h2233_44DD);
    dir(0, LWR, 1, 64'h1122_3344, 64'hAABB_CCDD, 5'd2, 1'b1, 64'hAABB_1122);
    dir(0, 4'd12, 1, 64'h1234_5678, 64'h0, 5'd3, 1'b1, 64'h1234_5678);
    drain(0);

    // ---- 32-bit: LWL then LWR to rd 5 with the LWL result held one cycle ----
    dir(0, LWL, 2, 64'h1122_3344, 64'hAABB_CCDD, 5'd5, 1'b1, 64'h3344_CCDD);
    dir(0, LWR, 1, 64'h5566_7788, 64'h0, 5'd5, 1'b0, 64'h0);
    dir(0, LWR, 1, 64'h5566_7788, 64'h0, 5'd5, 1'b1, 64'h3344_5566);
    drain(0);

    // ---- 32-bit: three stalled cycles, then one result per cycle ----
    mdl(0, 1'b1, LW, 0, 64'hCAFE_0001, 64'h0, 5'd7, 1'b1);
    for (int i = 0; i < 3; i++) mdl(0, 1'b1, LW, 0, 64'hCAFE_0002, 64'h0, 5'd8, 1'b0);
    for (int i = 0; i < 4; i++) mdl(0, 1'b1, LBU, i, 64'h0102_0304 + 64'(i), 64'h0, 5'(9 + i), 1'b1);
    drain(0);

    // ---- misaligned word load ----
`ifdef LOAD_ALIGN_FAULT_EN
    mdl(0, 1'b1, LW, 2, 64'h8142_C3F4, 64'h0, 5'd4, 1'b1);
    chk("fault_first", 70'(fcnt_a), 70'd1);
    for (int i = 0; i < 300; i++) mdl(0, 1'b1, LW, 2, {32'h0, $urandom}, 64'h0, 5'd4, 1'b1);
    chk("fault_sat", 70'(fcnt_a), 70'd255);
`else
    dir(0, LW, 2, 64'h8142_C3F4, 64'h0, 5'd4, 1'b1, 64'h8142_C3F4);
    dir(0, LH, 3, 64'h8142_C3F4, 64'h0, 5'd4, 1'b1, 64'hFFFF_C3F4);
`endif
    drain(0);

    rand_run(0, 250);
    drain(0);

    // ---- 64-bit ----
    dir(1, LD,  0, 64'h0123_4567_89AB_CDEF, 64'h0, 5'd1, 1'b1, 64'h0123_4567_89AB_CDEF);
    dir(1, LWU, 4, 64'hDEAD_BEEF_8000_0001, 64'h0, 5'd2, 1'b1, 64'h0000_0000_8000_0001);
    dir(1, LW,  4, 64'hDEAD_BEEF_8000_0001, 64'h0, 5'd3, 1'b1, 64'hFFFF_FFFF_8000_0001);
    dir(1, LB,  7, 64'h0000_0000_0000_0080, 64'h0, 5'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FF80);
    dir(1, LWL, 5, 64'h0000_0000_1122_3344, 64'h0000_0000_AABB_CCDD, 5'd6, 1'b1,
        64'h0000_0000_2233_44DD);
    drain(1);
    rand_run(1, 250);

    // ---- 64-bit: reset while a result is held ----
    dir(1, LBU, 0, 64'hFF00_0000_0000_0000, 64'h0, 5'd9, 1'b0, 64'h0000_0000_0000_00FF);
    chk("pre_reset_valid", 70'(ovld_b), 70'd1);
    rst_n = 1'b0;
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    #1;
    chk("reset_valid64", 70'(ovld_b), 70'd0);
    chk("reset_out64", get_out(1), 70'd0);
    exp_q0.delete();
    exp_q1.delete();
    for (int s = 0; s < 2; s++) begin
      m_hv[s] = 1'b0;
      m_fc[s] = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    dir(1, LH, 6, 64'h0000_0000_0000_7FFF, 64'h0, 5'd3, 1'b1, 64'h0000_0000_0000_7FFF);
    drain(1);
    drain(0);

    chk("queue32_empty", 70'(qsize(0)), 70'd0);
    chk("queue64_empty", 70'(qsize(1)), 70'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
